exec_unit: RTL and testbench
============================

# exec_unit

Parametrised RV32I/RV32M execute unit, successor to the combinational ALU-control decode. It takes ALUOp/funct fields plus two operands through a valid/ready handshake, decodes an extended 5-bit operation code, and returns a registered result. Base-ISA ops take 1 cycle; multiply/divide run on a shared iterative datapath over XLEN cycles. It sits between register-read and writeback in the multi-cycle core.

## Interface
- XLEN, 32: operand/result width; power of two, ≥8
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of any in-flight or held operation
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- funct7_30  in  1  instr[30]
- funct7_25  in  1  instr[25]; selects M-extension when alu_op=10
- funct3  in  3  instr[14:12]
- op_a, op_b  in  XLEN  operands (op_b is immediate for I-type)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- illegal  out  1  qualified by out_valid; encoding undecoded, result=0

## Operation
- Decode (combinational, in accept cycle) to op code: AND 00000, OR 00001, ADD 00010, SLL 00011, SLT 00100, SLTU 00101, SUB 00110, XOR 00111, SRL 01000, SRA 01010, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- alu_op 00/01 → ADD/SUB regardless of funct. alu_op 10, funct7_25=0: {funct7_30,funct3} as base R-type; 1000 SUB, 1101 SRA, other funct7_30=1 combos illegal. alu_op 10, funct7_25=1: funct3 0–7 → MUL..REMU in order above (funct7_30 must be 0, else illegal). alu_op 11: funct7_30 ignored except funct3=101 (SRAI vs SRLI); funct3=001 with funct7_30=1 illegal.
- Shift amount = op_b[$clog2(XLEN)-1:0]. SLT signed, SLTU unsigned, result zero-extended 0/1.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_valid&in_ready → base op or div special case: compute, load result, → DONE. M op otherwise: load datapath, count=0, → BUSY.
  - BUSY: one iteration per cycle; at count=XLEN-1 load result, → DONE.
  - DONE: out_valid=1; result/illegal held stable until out_ready. out_ready → IDLE, or directly accept a new op in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready); never in BUSY.
- Multiply: shift-add on magnitudes, 2·XLEN-bit product; sign applied at end per op (MULH both signed, MULHSU op_a signed, MULHU none). MUL returns low half, MULH* high half.
- Divide: restoring, on magnitudes; quotient negated if signs differ, remainder takes dividend sign.
- Special cases (1-cycle, no BUSY): divisor 0 → DIV/DIVU = all-ones, REM/REMU = op_a. DIV/REM with op_a = most-negative, op_b = −1 → quotient op_a, remainder 0.
- flush: forces IDLE, out_valid=0 next edge; takes priority over in_valid the same cycle (no accept).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, illegal 0, counter 0.
- Accept at edge t: base/illegal/special → out_valid at t+1. M iterative → BUSY t+1..t+XLEN, out_valid at t+XLEN+1.
- Back-to-back base ops with out_ready held high: one result per cycle.
- rst mid-BUSY: immediate return to reset values, operation discarded.
- out_ready while out_valid=0: ignored.

## Structure
- Package exec_pkg: op-code localparams, alu_op encodings, state enum, shared decode function.
- One sub-module: mdu_iter (shared multiply/divide iteration: operand/partial registers, counter, sign fix-up, done pulse). Base ALU and FSM stay in exec_unit.

## Test plan
- Reset mid-BUSY of DIV 100/7 → next cycle out_valid=0, in_ready=1, result=0.
- Back-to-back ADD 5+3, SUB 5−3, SRA 0x80000000>>>4, out_ready=1 → results 8, 2, 0xF8000000 on consecutive cycles.
- MULH 0x80000000×0x80000000 → out_valid exactly 33 cycles after accept, result 0x40000000; MUL −3×7 → 0xFFFFFFEB.
- DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF at t+1; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- alu_op=10, funct7_30=1, funct3=001 → out_valid t+1, illegal=1, result=0.
- DIVU in flight, flush asserted with in_valid high → no accept that cycle; idle next; following ADD 1+1 returns 2; out_ready held low keeps result stable for 5 cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: op codes, alu_op encodings, FSM states and the shared
// ALUOp/funct decode for the execute unit.
package exec_pkg;
    localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010, OP_SLL = 5'b00011,
                           OP_SLT = 5'b00100, OP_SLTU = 5'b00101, OP_SUB = 5'b00110, OP_XOR = 5'b00111,
                           OP_SRL = 5'b01000, OP_SRA = 5'b01010;
    localparam logic [1:0] OP_M_HI = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_R = 2'b10, ALU_I = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic       illegal;
        logic [4:0] op;
    } dec_t;
    function automatic dec_t decode(input logic [1:0] alu_op, input logic f30, input logic f25,
                                    input logic [2:0] f3);
        logic       alt;
        logic [4:0] base;
        dec_t       d;
        // I-type only honours instr[30] for SRAI; R-type uses it for SUB/SRA
        alt = f30 && (alu_op == ALU_R || f3 == 3'b101);
        case (f3)
            3'b000: base = alt ? OP_SUB : OP_ADD;
            3'b001: base = OP_SLL;
            3'b010: base = OP_SLT;
            3'b011: base = OP_SLTU;
            3'b100: base = OP_XOR;
            3'b101: base = alt ? OP_SRA : OP_SRL;
            3'b110: base = OP_OR;
            default: base = OP_AND;
        endcase
        d.op = alu_op == ALU_ADD ? OP_ADD : alu_op == ALU_SUB ? OP_SUB :
               (alu_op == ALU_R && f25) ? {OP_M_HI, f3} : base;
        d.illegal = alu_op == ALU_R ? f30 && (f25 || (f3 != 3'b000 && f3 != 3'b101)) :
                    alu_op == ALU_I && f30 && f3 == 3'b001;
        return d;
    endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: shared shift-add multiplier / restoring divider on operand
// magnitudes, one iteration per cycle for XLEN cycles, sign fixed at the end.
module mdu_iter #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      fn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);
    logic              run, div, neg_q, neg_r, a_sgn, b_sgn, sa, sb;
    logic [1:0]        sel;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   m, hi, lo, hi_n, lo_n;
    logic [XLEN:0]     sum, shl, dif;
    logic [2*XLEN-1:0] prod;
    assign a_sgn = fn[2] ? !fn[0] : (fn[1:0] == 2'b01 || fn[1:0] == 2'b10);
    assign b_sgn = fn[2] ? !fn[0] : fn[1:0] == 2'b01;
    assign sa    = a_sgn && a[XLEN-1];
    assign sb    = b_sgn && b[XLEN-1];
    // hi:lo is the product accumulator for multiply, remainder:quotient for divide
    assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign shl   = {hi, lo[XLEN-1]};
    assign dif   = shl - {1'b0, m};
    assign hi_n  = div ? (dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0]) : sum[XLEN:1];
    assign lo_n  = div ? {lo[XLEN-2:0], !dif[XLEN]} : {sum[0], lo[XLEN-1:1]};
    assign prod  = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    assign res   = div ? (sel[1] ? (neg_r ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n)) :
                   (sel == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign done  = run && count == CW'(XLEN - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            run   <= 1'b0;
            div   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            sel   <= '0;
            count <= '0;
            m     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            run   <= 1'b0;
            count <= '0;
        end else if (start) begin
            run   <= 1'b1;
            count <= '0;
            div   <= fn[2];
            sel   <= fn[1:0];
            neg_q <= sa ^ sb;
            neg_r <= sa;
            m     <= sb ? -b : b;
            hi    <= '0;
            lo    <= sa ? -a : a;
        end else if (run) begin
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count + 1'b1;
            run   <= !done;
        end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: RV32I/M execute stage; single-cycle base ALU plus an iterative
// multiply/divide, behind a valid/ready handshake with a registered result.
module exec_unit import exec_pkg::*; #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            funct7_30,
    input  logic            funct7_25,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    state_t          state;
    dec_t            dec;
    logic            accept, is_div, zero, ovf, special, mdu_start, mdu_done;
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] alu, fast, mdu_res;
    assign dec       = decode(alu_op, funct7_30, funct7_25, funct3);
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = state == DONE;
    assign sh        = op_b[SW-1:0];
    assign is_div    = dec.op[4] && dec.op[2];
    assign zero      = op_b == '0;
    assign ovf       = !dec.op[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
    assign special   = is_div && (zero || ovf);
    assign mdu_start = accept && dec.op[4] && !dec.illegal && !special;
    always_comb
        case (dec.op)
            OP_AND:  alu = op_a & op_b;
            OP_OR:   alu = op_a | op_b;
            OP_ADD:  alu = op_a + op_b;
            OP_SLL:  alu = op_a << sh;
            OP_SLT:  alu = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu = XLEN'(op_a < op_b);
            OP_SUB:  alu = op_a - op_b;
            OP_XOR:  alu = op_a ^ op_b;
            OP_SRL:  alu = op_a >> sh;
            OP_SRA:  alu = $signed(op_a) >>> sh;
            default: alu = '0;
        endcase
    // divide-by-zero and signed overflow resolve in one cycle without the iterator
    assign fast = dec.illegal ? '0 :
                  special ? (zero ? (dec.op[1] ? op_a : '1) : (dec.op[1] ? '0 : op_a)) : alu;
    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (mdu_start),
        .fn    (dec.op[2:0]),
        .a     (op_a),
        .b     (op_b),
        .done  (mdu_done),
        .res   (mdu_res)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            illegal <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            state   <= mdu_start ? BUSY : DONE;
            result  <= mdu_start ? result : fast;
            illegal <= dec.illegal;
        end else if (state == BUSY && mdu_done) begin
            state   <= DONE;
            result  <= mdu_res;
            illegal <= 1'b0;
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vectors; expected results are queued at issue and
// checked by an independent monitor when the unit hands a result over.
module tb_exec_unit;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic        funct7_30 = 0, funct7_25 = 0;
    logic [1:0]  alu_op = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] result;
    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        int          due;
    } exp_t;
    exp_t  sb[$];
    string names[$];
    exp_t  e;
    string nm;
    int    cyc = 0, tests = 0, fails = 0, t0 = 0;
    logic  seen = 0, moved = 0;
    logic [31:0] held = 0;

    exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7_30(funct7_30), .funct7_25(funct7_25), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic f30, input logic f25,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill, input int lat, input bit track);
        int n = 0;
        alu_op = op; funct7_30 = f30; funct7_25 = f25; funct3 = f3; op_a = a; op_b = b; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({name, " accept timeout"}, in_ready, 1);
        else if (track) begin
            sb.push_back('{exp_res, exp_ill, cyc + lat});
            names.push_back(name);
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // monitor: first-presentation cycle, stability while held, compare on handshake
    always @(negedge clk) begin
        if (!out_valid) seen = 0;
        else begin
            if (!seen) begin
                seen = 1; t0 = cyc; held = result; moved = 0;
            end else if (result !== held) moved = 1;
            if (out_ready) begin
                if (sb.size() == 0) check("unexpected output", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    nm = names.pop_front();
                    check({nm, " result/illegal"}, {illegal, result}, {e.ill, e.res});
                    check({nm, " latency"}, t0, e.due);
                    check({nm, " stable"}, moved, 0);
                end
                seen = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset result", result, 0);
        check("reset illegal", illegal, 0);
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        issue("add", 2'b00, 0, 0, 3'b000, 5, 3, 8, 0, 1, 1);
        issue("sub", 2'b01, 0, 0, 3'b000, 5, 3, 2, 0, 1, 1);
        issue("sra", 2'b10, 1, 0, 3'b101, 32'h8000_0000, 4, 32'hF800_0000, 0, 1, 1);
        drain();
        issue("div_rst", 2'b10, 0, 1, 3'b100, 100, 7, 0, 0, 33, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("rst busy out_valid", out_valid, 0);
        check("rst busy in_ready", in_ready, 1);
        check("rst busy result", result, 0);
        #1 rst = 0;
        @(posedge clk);
        #1;
        issue("xor", 2'b10, 0, 0, 3'b100, 32'hF0F0, 32'h0FF0, 32'hFF00, 0, 1, 1);
        issue("or", 2'b10, 0, 0, 3'b110, 32'hF0F0, 32'h0FF0, 32'hFFF0, 0, 1, 1);
        issue("and", 2'b10, 0, 0, 3'b111, 32'hF0F0, 32'h0FF0, 32'h00F0, 0, 1, 1);
        issue("srl", 2'b10, 0, 0, 3'b101, 32'h8000_0000, 4, 32'h0800_0000, 0, 1, 1);
        issue("sub_r", 2'b10, 1, 0, 3'b000, 5, 7, 32'hFFFF_FFFE, 0, 1, 1);
        issue("slti", 2'b11, 0, 0, 3'b010, 32'hFFFF_FFFF, 1, 1, 0, 1, 1);
        issue("sltiu", 2'b11, 0, 0, 3'b011, 32'hFFFF_FFFF, 1, 0, 0, 1, 1);
        issue("slli", 2'b11, 0, 0, 3'b001, 1, 32'h25, 32'h20, 0, 1, 1);
        issue("addi_f30", 2'b11, 1, 0, 3'b000, 5, 3, 8, 0, 1, 1);
        issue("srai", 2'b11, 1, 0, 3'b101, 32'h8000_0000, 4, 32'hF800_0000, 0, 1, 1);
        issue("illegal_r", 2'b10, 1, 0, 3'b001, 5, 3, 0, 1, 1, 1);
        issue("illegal_i", 2'b11, 1, 0, 3'b001, 5, 3, 0, 1, 1, 1);
        issue("illegal_m", 2'b10, 1, 1, 3'b000, 5, 3, 0, 1, 1, 1);
        issue("mulh", 2'b10, 0, 1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 33, 1);
        issue("mul", 2'b10, 0, 1, 3'b000, 32'hFFFF_FFFD, 7, 32'hFFFF_FFEB, 0, 33, 1);
        issue("mulhu", 2'b10, 0, 1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 1);
        issue("mulhsu", 2'b10, 0, 1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33, 1);
        issue("div", 2'b10, 0, 1, 3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0, 33, 1);
        issue("rem", 2'b10, 0, 1, 3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0, 33, 1);
        issue("divu", 2'b10, 0, 1, 3'b101, 100, 7, 14, 0, 33, 1);
        issue("remu", 2'b10, 0, 1, 3'b111, 100, 7, 2, 0, 33, 1);
        issue("divu_zero", 2'b10, 0, 1, 3'b101, 7, 0, 32'hFFFF_FFFF, 0, 1, 1);
        issue("rem_zero", 2'b10, 0, 1, 3'b110, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, 0, 1, 1);
        issue("div_ovf", 2'b10, 0, 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1);
        issue("rem_ovf", 2'b10, 0, 1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 1);
        drain();
        issue("divu_flush", 2'b10, 0, 1, 3'b101, 100, 7, 0, 0, 33, 0);
        repeat (5) @(posedge clk);
        #1 flush = 1; in_valid = 1; alu_op = 2'b00; op_a = 1; op_b = 1;
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush busy out_valid", out_valid, 0);
        check("flush busy in_ready", in_ready, 1);
        @(posedge clk);
        #1 flush = 1; in_valid = 1;
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush blocks accept", out_valid, 0);
        @(posedge clk);
        #1 out_ready = 0;
        issue("add_hold", 2'b00, 0, 0, 3'b000, 1, 1, 2, 0, 1, 1);
        repeat (5) @(negedge clk);
        check("hold out_valid", out_valid, 1);
        check("hold result", result, 2);
        @(posedge clk);
        #1 out_ready = 1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
